// File: rtl/weight_bit_serializer.sv
// Bit-serial sign-magnitude weight transmitter: small word FIFO feeding a shift register,
// magnitude MSB first then sign. Define WSER_GAP_EN for a one-cycle multiplier-clear gap per frame.
module weight_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         w_data,
  input  logic                     w_valid,
  output logic                     w_ready,
  output logic                     weight_bit,
  output logic                     bit_valid,
  output logic                     frame_start,
  output logic                     frame_last,
  output logic                     mult_clear_n,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(WIDTH);

`ifdef WSER_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] head;
  logic             push, pop, last_bit, fifo_ne;

  assign head     = mem_q[rd_ptr_q];
  assign fifo_ne  = (count_q != '0);
  assign push     = w_valid && (count_q < CW'(DEPTH));
  assign last_bit = (bitcnt_q == BW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_ne) pop = 1'b1;
      end
      S_SHIFT: begin
        if (last_bit) begin
`ifdef WSER_GAP_EN
          state_d = S_GAP;
`else
          if (fifo_ne) pop = 1'b1;
          else         state_d = S_IDLE;
`endif
        end else begin
          bitcnt_d = bitcnt_q + BW'(1);
          shreg_d  = shreg_q << 1;
        end
      end
`ifdef WSER_GAP_EN
      S_GAP: begin
        if (fifo_ne) pop = 1'b1;
        else         state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Rotate the sign below the magnitude so the frame shifts straight out of the MSB.
    if (pop) begin
      state_d  = S_SHIFT;
      bitcnt_d = '0;
      shreg_d  = {head[WIDTH-2:0], head[WIDTH-1]};
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= w_data;
  end

  assign bit_valid   = (state_q == S_SHIFT);
  assign weight_bit  = bit_valid && shreg_q[WIDTH-1];
  assign frame_start = bit_valid && (bitcnt_q == '0);
  assign frame_last  = bit_valid && last_bit;
  assign w_ready     = (count_q < CW'(DEPTH));
  assign fifo_count  = count_q;
  assign busy        = (state_q != S_IDLE) || fifo_ne;
`ifdef WSER_GAP_EN
  assign mult_clear_n = (state_q != S_GAP);
`else
  assign mult_clear_n = 1'b1;
`endif

endmodule

// File: doc/weight_bit_serializer.md
# weight_bit_serializer

Bit-serial weight transmitter for the accelerator's multiply datapath. It buffers parallel sign-magnitude weight words in a small FIFO and shifts each word out one bit per clock in the frame order the bit-serial multiplier consumes: magnitude MSB first, then the sign bit. Frame-marker outputs let the multiplier and the downstream accumulator align to word boundaries.

## Interface
- WIDTH, 8: weight word width; bit WIDTH-1 is the sign, bits WIDTH-2..0 are the magnitude; the frame length is WIDTH cycles.
- DEPTH, 4: FIFO depth in words; must be a power of 2 and at least 2.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- w_data  in  WIDTH  weight word, sign-magnitude.
- w_valid  in  1  w_data is valid.
- w_ready  out  1  FIFO can accept a word; equals count < DEPTH.
- weight_bit  out  1  serial weight bit; forced to 0 when bit_valid=0.
- bit_valid  out  1  weight_bit is meaningful this cycle.
- frame_start  out  1  high on bit 0 of each frame.
- frame_last  out  1  high on the sign-bit cycle, which is the last bit of the frame.
- mult_clear_n  out  1  active-low multiplier clear pulse (see Configuration).
- fifo_count  out  $clog2(DEPTH)+1  number of words held in the FIFO.
- busy  out  1  a frame is being shifted, or the FIFO is non-empty.

## Operation
- Push: a word is written on an edge where w_valid && w_ready. When the FIFO is full (w_ready=0), w_valid is ignored. There is no bypass path.
- The FIFO uses circular read and write pointers that wrap at DEPTH. A push and a pop on the same edge leave fifo_count unchanged.
- The FSM has three states: IDLE, SHIFT, and GAP. The GAP state exists only when the macro is defined.
  - IDLE → SHIFT: on an edge where the FIFO is non-empty. That edge pops the head word into the shift register and sets bitcnt=0.
  - SHIFT: bitcnt increments on every edge.
  - Output order during SHIFT: for bitcnt 0..WIDTH-2, weight_bit = word[WIDTH-2-bitcnt]. For bitcnt = WIDTH-1, weight_bit = word[WIDTH-1] (the sign).
  - End of frame, at the edge where bitcnt = WIDTH-1, with no gap configured:
    - FIFO non-empty: pop the next word and stay in SHIFT with bitcnt=0. There is no bubble between frames.
    - FIFO empty: go to IDLE.
  - End of frame with the gap configured: go to GAP.
- All outputs are registered. Every output is a decode of the state and counters held in flops.
- Reset value of every output while reset=0 or immediately after reset:
  - weight_bit=0, bit_valid=0, frame_start=0, frame_last=0.
  - mult_clear_n=1, w_ready=1, fifo_count=0, busy=0.
  - FIFO is emptied.
- Reset asserted mid-frame abandons the frame. No partial bits are emitted after reset is released.

## Timing
- Latency: a word accepted at edge k into an empty, idle block is popped at edge k+1. Its bit 0 is visible, with bit_valid=1 and frame_start=1, in the cycle after edge k+1.
- A frame is exactly WIDTH consecutive cycles with bit_valid=1.
- frame_start and frame_last are each high for exactly one cycle per frame.
- w_ready and fifo_count update in the cycle after the accepting or popping edge.
- Sustained throughput is one word per WIDTH cycles without the gap, and one word per WIDTH+1 cycles with the gap.

## Configuration
- Macro: WSER_GAP_EN.
- When defined:
  - After every frame, the FSM spends one cycle in GAP. During that cycle bit_valid=0, weight_bit=0, and mult_clear_n=0.
  - The FSM then pops the next word if the FIFO is non-empty, otherwise it goes to IDLE.
  - The GAP cycle restarts the multiplier's bit counter between words.
- When undefined:
  - The GAP state is absent and mult_clear_n is tied to 1.
  - Frames run back to back.

## Test plan
- Single word: push 0xA5 into an idle block → bit_valid for 8 cycles carrying weight_bit 0,1,0,0,1,0,1,1; frame_start on cycle 1, frame_last on cycle 8; busy then falls to 0.
- Back-to-back, macro undefined: push 0x03 then 0x81 on consecutive edges → 16 contiguous valid cycles carrying 0,0,0,0,0,1,1,0 then 0,0,0,0,0,0,1,1; frame_start twice, 8 cycles apart.
- Full FIFO, DEPTH=4: hold w_valid high from edge 0 →
  - words accepted on edges 0–4;
  - fifo_count=4 and w_ready=0 after edge 4;
  - w_ready returns to 1 after the pop at edge 9;
  - the sixth word is accepted at edge 10;
  - no word is lost or duplicated.
- Simultaneous push and pop at count=2 → fifo_count remains 2.
- Reset mid-frame: assert reset on bit 3 of 0xFF → all outputs are at their reset values immediately; after release, nothing is emitted until a new push.
- WSER_GAP_EN defined: push two words → one cycle with bit_valid=0 and mult_clear_n=0 between the frames; 17 cycles total from the first bit to the last.
